sevenseg_scan_ctrl: RTL and testbench
=====================================

// Module: sevenseg_scan_ctrl
// PURPOSE
//   Time-multiplexed driver for the Nexys A7 8-digit common-anode seven-segment display.
//   Sits directly downstream of the SweRVolf display register and directly drives the board pins
//   AN[7:0] and {CA,CB,CC,CD,CE,CF,CG}.
//   Decodes hex nibbles and scans the digits with anti-ghost blanking.
//   Buffers each update and applies it only on a frame boundary, so a frame never shows a mix of
//   old and new digits.
// PARAMETERS
//   NDIGITS       8      number of digits scanned (legal range 1..8)
//   DIGIT_CYCLES  50000  clk cycles per digit slot (1 ms at 50 MHz); must be >= 2
//   BLANK_CYCLES  500    cycles at the start of each slot with all anodes off; must be < DIGIT_CYCLES
// PORTS
//   clk           in   1            core clock (clk_core domain)
//   rstn          in   1            asynchronous active-low reset
//   i_update      in   1            one-cycle strobe: capture i_digits and i_en_mask into the pending buffer
//   i_digits      in   4*NDIGITS    hex value per digit; nibble k is digit k (digit 0 = rightmost)
//   i_en_mask     in   NDIGITS      1 = digit k lit; 0 = digit k dark for its slot
//   o_an          out  NDIGITS      anode enables, active-low, registered
//   o_seg         out  7            {CA..CG}, active-low, CA is the MSB, registered
//   o_frame_done  out  1            one-cycle pulse at each frame wrap
// BEHAVIOUR
// - Reset values (asynchronous, on rstn=0):
//   - o_an = all 1s, o_seg = 7'h7F, o_frame_done = 0
//   - idx = 0, cnt = 0
//   - shadow digits = 0, shadow mask = 0, so the display stays dark until the first update
//   - pending digits/mask = 0, pend_flag = 0
// - Slot counter cnt: 0..DIGIT_CYCLES-1, +1 every cycle.
//   - At DIGIT_CYCLES-1: cnt wraps to 0 and idx increments.
//   - idx wraps NDIGITS-1 -> 0.
// - Slot state is derived from cnt:
//   - BLANK when cnt < BLANK_CYCLES
//   - DRIVE when cnt >= BLANK_CYCLES
//   - BLANK -> DRIVE at cnt == BLANK_CYCLES.
//   - DRIVE -> BLANK of the next slot at the cnt wrap.
// - Outputs are registered: 1-cycle latency from state/idx.
//   - BLANK: o_an = all 1s, o_seg = 7'h7F.
//   - DRIVE with shadow_mask[idx] = 1: o_an = ~(1 << idx), o_seg = hex7(shadow_digits[idx]).
//   - DRIVE with shadow_mask[idx] = 0: o_an = all 1s, o_seg = 7'h7F. The slot still consumes its
//     full time, so the refresh rate does not depend on the mask.
// - hex7 table (active-low, order a..g):
//   - 0:0000001  1:1001111  2:0010010  3:0000110  4:1001100  5:0100100  6:0100000  7:0001111
//   - 8:0000000  9:0000100  A:0001000  b:1100000  C:0110001  d:1000010  E:0110000  F:0111000
// - Update buffering:
//   - i_update = 1 loads the pending regs and sets pend_flag.
//   - A later update before the frame wrap overwrites pending; the last one wins.
// - Frame wrap event: idx == NDIGITS-1 and cnt == DIGIT_CYCLES-1. On the next edge:
//   - o_frame_done = 1 for one cycle.
//   - If pend_flag = 1: shadow <= pending and pend_flag <= 0.
// - Simultaneous events: i_update in the same cycle as the wrap event lands in pending only. It is
//   displayed from the frame after next; shadow takes the previously pending value, if any.
// - No other path writes shadow. Out-of-range nibbles cannot occur (4-bit).
// - rstn asserted mid-slot:
//   - Outputs blank immediately (asynchronously).
//   - Pending and shadow are cleared.
//   - After release, scan restarts at slot 0 in BLANK.
// TESTING (bench overrides: NDIGITS=8, DIGIT_CYCLES=8, BLANK_CYCLES=2; frame = 64 cycles)
// 1. Reset release, no update -> o_an=8'hFF, o_seg=7'h7F for 200 cycles; o_frame_done pulses
//    every 64 cycles.
// 2. i_update with i_digits=32'h76543210, i_en_mask=8'hFF -> after the next o_frame_done:
//    - slot 0: o_an=8'hFF for 2 cycles, then 8'hFE with o_seg=7'b0000001 for 6 cycles
//    - slot 7: o_an=8'h7F with o_seg=7'b0001111
// 3. Digits 32'hFEDCBA98 then 32'h76543210 -> every slot matches the hex7 table for all 16 values.
// 4. Two updates within one frame (32'h11111111, then 32'h22222222) -> the next frame shows only 2s;
//    1s never appear.
// 5. i_en_mask=8'b1010_1010 -> slots 0,2,4,6: o_an=8'hFF, o_seg=7'h7F for all 8 cycles;
//    odd slots lit. Also check i_update coincident with the wrap cycle -> data visible only after
//    the following o_frame_done.
// 6. rstn low at cnt=5 of slot 3 while driving -> o_an=8'hFF and o_seg=7'h7F without waiting for
//    a clk edge. After release: dark until a new update plus a frame wrap; scan resumes at slot 0.

Source files
------------

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Each digit slot starts with an anti-ghost blank window. Updates are buffered and applied at frame wrap.
module sevenseg_scan_ctrl #(
  parameter int NDIGITS      = 8,
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_update,
  input  logic [4*NDIGITS-1:0]   i_digits,
  input  logic [NDIGITS-1:0]     i_en_mask,
  output logic [NDIGITS-1:0]     o_an,
  output logic [6:0]             o_seg,
  output logic                   o_frame_done
);

  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int CNT_W = $clog2(DIGIT_CYCLES);

  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NDIGITS - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [NDIGITS-1:0] AN_ONE    = NDIGITS'(1);
  localparam logic [NDIGITS-1:0] AN_OFF    = '1;
  localparam logic [6:0]         SEG_OFF   = 7'h7F;

  typedef enum logic {S_BLANK, S_DRIVE} slot_state_e;

  localparam slot_state_e ST_RST = (BLANK_CYCLES > 0) ? S_BLANK : S_DRIVE;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'b0000001;
      4'h1:    hex7 = 7'b1001111;
      4'h2:    hex7 = 7'b0010010;
      4'h3:    hex7 = 7'b0000110;
      4'h4:    hex7 = 7'b1001100;
      4'h5:    hex7 = 7'b0100100;
      4'h6:    hex7 = 7'b0100000;
      4'h7:    hex7 = 7'b0001111;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0000100;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b1100000;
      4'hC:    hex7 = 7'b0110001;
      4'hD:    hex7 = 7'b1000010;
      4'hE:    hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic [IDX_W-1:0]     idx;
  logic                 cnt_wrap;
  logic                 frame_wrap;
  slot_state_e          state_q, state_d;

  logic [4*NDIGITS-1:0] pend_digits, shadow_digits;
  logic [NDIGITS-1:0]   pend_mask, shadow_mask;
  logic                 pend_flag;

  logic [3:0]           cur_nib;
  logic [NDIGITS-1:0]   an_d;
  logic [6:0]           seg_d;

  assign cnt_wrap   = (cnt == CNT_LAST);
  assign frame_wrap = cnt_wrap && (idx == IDX_LAST);
  assign cnt_nxt    = cnt_wrap ? '0 : cnt + 1'b1;

  // Slot timing: cnt walks the slot, idx walks the digits
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (cnt_wrap) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_RST;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = (cnt_nxt < CNT_BLANK) ? S_BLANK : S_DRIVE;
  end

  // Pending holds the newest request; shadow is what the scan shows and only changes at frame wrap
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_digits   <= '0;
      pend_mask     <= '0;
      pend_flag     <= 1'b0;
      shadow_digits <= '0;
      shadow_mask   <= '0;
    end else begin
      if (i_update) begin
        pend_digits <= i_digits;
        pend_mask   <= i_en_mask;
      end
      if (frame_wrap && pend_flag) begin
        shadow_digits <= pend_digits;
        shadow_mask   <= pend_mask;
      end
      if (i_update)        pend_flag <= 1'b1;
      else if (frame_wrap) pend_flag <= 1'b0;
    end
  end

  assign cur_nib = shadow_digits[{idx, 2'b00} +: 4];

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (state_q == S_DRIVE && shadow_mask[idx]) begin
      an_d  = ~(AN_ONE << idx);
      seg_d = hex7(cur_nib);
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_an         <= AN_OFF;
      o_seg        <= SEG_OFF;
      o_frame_done <= 1'b0;
    end else begin
      o_an         <= an_d;
      o_seg        <= seg_d;
      o_frame_done <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl with an 8-cycle slot, 2-cycle blank and 64-cycle frame.
module tb_sevenseg_scan_ctrl;

  localparam int NDIGITS = 8;
  localparam int DCYC    = 8;
  localparam int BCYC    = 2;
  localparam int FRAME   = NDIGITS * DCYC;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_update;
  logic [31:0] i_digits;
  logic [7:0]  i_en_mask;
  logic [7:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_frame_done;

  int checks = 0;
  int errors = 0;

  logic [6:0] hex7_ref [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  sevenseg_scan_ctrl #(
    .NDIGITS(NDIGITS),
    .DIGIT_CYCLES(DCYC),
    .BLANK_CYCLES(BCYC)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .i_update(i_update),
    .i_digits(i_digits),
    .i_en_mask(i_en_mask),
    .o_an(o_an),
    .o_seg(o_seg),
    .o_frame_done(o_frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic do_update(input logic [31:0] d, input logic [7:0] m);
    i_digits  = d;
    i_en_mask = m;
    i_update  = 1'b1;
    @(negedge clk);
    i_update  = 1'b0;
  endtask

  // Expects the current negedge to be inside an o_frame_done cycle; checks the whole next frame.
  task automatic frame_body(input logic [31:0] d, input logic [7:0] m);
    int s, pos;
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    logic [3:0] nib;
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      s   = (k - 1) / DCYC;
      pos = (k - 1) % DCYC;
      nib = d[4*s +: 4];
      if (pos < BCYC || !m[s]) begin
        exp_an  = 8'hFF;
        exp_seg = 7'h7F;
      end else begin
        exp_an  = ~(8'h01 << s);
        exp_seg = hex7_ref[nib];
      end
      check_eq($sformatf("an_s%0d_p%0d", s, pos), 32'(o_an), 32'(exp_an));
      check_eq($sformatf("seg_s%0d_p%0d", s, pos), 32'(o_seg), 32'(exp_seg));
      check_eq($sformatf("fd_k%0d", k), 32'(o_frame_done), 32'(k == FRAME));
    end
  endtask

  task automatic wait_fd();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (o_frame_done) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check_eq("fd_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_frame(input logic [31:0] d, input logic [7:0] m);
    wait_fd();
    frame_body(d, m);
  endtask

  // Dark display for n cycles after reset release; frame pulses every FRAME cycles.
  task automatic dark_run(input int n);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      check_eq($sformatf("dark_an_%0d", i), 32'(o_an), 32'hFF);
      check_eq($sformatf("dark_seg_%0d", i), 32'(o_seg), 32'h7F);
      check_eq($sformatf("dark_fd_%0d", i), 32'(o_frame_done), 32'(i % FRAME == 0));
    end
  endtask

  initial begin
    rstn      = 1'b0;
    i_update  = 1'b0;
    i_digits  = '0;
    i_en_mask = '0;

    // 1: reset values, then dark scan with frame pulses
    repeat (3) @(negedge clk);
    check_eq("rst_an", 32'(o_an), 32'hFF);
    check_eq("rst_seg", 32'(o_seg), 32'h7F);
    check_eq("rst_fd", 32'(o_frame_done), 32'h0);
    rstn = 1'b1;
    dark_run(200);

    // 2: first update, ascending digits
    do_update(32'h76543210, 8'hFF);
    check_frame(32'h76543210, 8'hFF);

    // 3: all sixteen glyphs
    do_update(32'hFEDCBA98, 8'hFF);
    check_frame(32'hFEDCBA98, 8'hFF);
    do_update(32'h76543210, 8'hFF);
    check_frame(32'h76543210, 8'hFF);

    // 4: last update before the wrap wins
    do_update(32'h11111111, 8'hFF);
    repeat (5) @(negedge clk);
    do_update(32'h22222222, 8'hFF);
    check_frame(32'h22222222, 8'hFF);

    // 5: masked digits, then update coincident with the wrap cycle
    do_update(32'h76543210, 8'b1010_1010);
    check_frame(32'h76543210, 8'b1010_1010);
    repeat (FRAME - 1) @(negedge clk);
    i_digits  = 32'hA5A5A5A5;
    i_en_mask = 8'hFF;
    i_update  = 1'b1;
    @(negedge clk);
    i_update  = 1'b0;
    check_eq("coinc_fd", 32'(o_frame_done), 32'h1);
    frame_body(32'h76543210, 8'b1010_1010);
    frame_body(32'hA5A5A5A5, 8'hFF);

    // 6: asynchronous reset mid-drive in slot 3, with an update left pending
    repeat (10) @(negedge clk);
    do_update(32'h11111111, 8'hFF);
    repeat (18) @(negedge clk);
    check_eq("pre_rst_an", 32'(o_an), 32'hF7);
    check_eq("pre_rst_seg", 32'(o_seg), 32'(hex7_ref[4'hA]));
    rstn = 1'b0;
    #1;
    check_eq("async_rst_an", 32'(o_an), 32'hFF);
    check_eq("async_rst_seg", 32'(o_seg), 32'h7F);
    check_eq("async_rst_fd", 32'(o_frame_done), 32'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    dark_run(80);
    do_update(32'h76543210, 8'hFF);
    check_frame(32'h76543210, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
